// File: rtl/loop_buffer_ctrl.sv
// Loop buffer controller: captures a short backward-branch loop from the fetch
// stream, then replays it from a local buffer while fetch is suppressed.
module loop_buffer_ctrl #(
   parameter int DEPTH          = 32,
   parameter int MAX_LOOP_BYTES = 128,
   localparam int AW            = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          valid_in,
   input  logic [31:0]   curr_PC,
   input  logic [31:0]   instruction,
   input  logic [31:0]   immediate,
   input  logic          bubble_idex,
   input  logic          mispredict,
   output logic          block_signal,
   output logic          flush,
   output logic [31:0]   new_pc,
   output logic [31:0]   out_instruction,
   output logic          out_valid,
   output logic [AW:0]   loop_len,
   output logic [1:0]    dbg_state,
   output logic [AW-1:0] dbg_rd_ptr
);

   // Handshake: valid_in qualifies curr_PC/instruction/immediate with no backpressure;
   // out_valid qualifies out_instruction, and bubble_idex=1 holds it for another cycle.
   typedef enum logic [1:0] {TRACK = 2'd0, CAPTURE = 2'd1, ARM = 2'd2, REPLAY = 2'd3} state_t;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   state_t        state;
   logic [31:0]   br_pc;
   logic [31:0]   tgt_pc;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_next;
   logic [AW-1:0] rd_addr;
   logic [31:0]   buffer [DEPTH];
   logic [6:0]    opcode;
   logic [31:0]   neg_imm;
   logic [31:0]   exp_pc;
   logic          is_cf;
   logic          is_candidate;
   logic          cap_match;
   logic          cap_write;

   always_comb begin
      opcode       = instruction[6:0];
      neg_imm      = 32'd0 - immediate;
      is_cf        = (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
      is_candidate = valid_in && ((opcode == OP_BRANCH) || (opcode == OP_JAL)) && immediate[31]
                     && (neg_imm >= 32'd4) && (neg_imm <= 32'(MAX_LOOP_BYTES));
      exp_pc       = tgt_pc + {{(30-AW){1'b0}}, wr_ptr, 2'b00};
      cap_match    = (state == CAPTURE) && valid_in && !mispredict && (curr_PC == exp_pc);
      cap_write    = cap_match && ((curr_PC == br_pc) || !is_cf);
      rd_next      = (({1'b0, rd_ptr} + 1'b1) == loop_len) ? '0 : rd_ptr + 1'b1;
      // ARM primes entry 0; REPLAY prefetches the entry shown after the next advance.
      rd_addr      = (state == REPLAY) ? rd_next : '0;
   end

   assign flush      = (state == REPLAY) && mispredict;
   assign dbg_state  = state;
   assign dbg_rd_ptr = rd_ptr;

   always_ff @(posedge clk) begin
      if (cap_write) buffer[wr_ptr] <= instruction;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= TRACK;
         br_pc           <= '0;
         tgt_pc          <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         loop_len        <= '0;
         new_pc          <= '0;
         out_instruction <= '0;
         block_signal    <= 1'b0;
         out_valid       <= 1'b0;
      end else begin
         case (state)
            TRACK: begin
               if (is_candidate && !mispredict) begin
                  br_pc  <= curr_PC;
                  tgt_pc <= curr_PC + immediate;
                  wr_ptr <= '0;
                  state  <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (mispredict) begin
                  state <= TRACK;
               end else if (valid_in) begin
                  if (curr_PC != exp_pc) begin
                     state <= TRACK;
                  end else if (curr_PC == br_pc) begin
                     loop_len     <= {1'b0, wr_ptr} + 1'b1;
                     new_pc       <= br_pc + 32'd4;
                     block_signal <= 1'b1;
                     state        <= ARM;
                  end else if (is_cf) begin
                     state <= TRACK;
                  end else if (wr_ptr == AW'(DEPTH - 1)) begin
                     // Buffer full and the closing branch still not seen.
                     state <= TRACK;
                  end else begin
                     wr_ptr <= wr_ptr + 1'b1;
                  end
               end
            end
            ARM: begin
               if (mispredict) begin
                  block_signal <= 1'b0;
                  state        <= TRACK;
               end else begin
                  rd_ptr          <= '0;
                  out_instruction <= buffer[rd_addr];
                  out_valid       <= 1'b1;
                  state           <= REPLAY;
               end
            end
            REPLAY: begin
               if (mispredict) begin
                  block_signal <= 1'b0;
                  out_valid    <= 1'b0;
                  rd_ptr       <= '0;
                  state        <= TRACK;
               end else if (!bubble_idex) begin
                  rd_ptr          <= rd_next;
                  out_instruction <= buffer[rd_addr];
               end
            end
            default: state <= TRACK;
         endcase
      end
   end

endmodule

// File: tb/tb_loop_buffer_ctrl.sv
// Bench for loop_buffer_ctrl: capture/replay, stalls, aborts, mispredicts and
// reset, with replayed words checked against a scoreboard queue.
module tb_loop_buffer_ctrl;

   localparam int AW = 5;
   localparam logic [31:0] ST_TRACK   = 32'd0;
   localparam logic [31:0] ST_CAPTURE = 32'd1;
   localparam logic [31:0] ST_ARM     = 32'd2;
   localparam logic [31:0] ST_REPLAY  = 32'd3;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_in;
   logic [31:0]   curr_PC;
   logic [31:0]   instruction;
   logic [31:0]   immediate;
   logic          bubble_idex;
   logic          mispredict;
   logic          block_signal;
   logic          flush;
   logic [31:0]   new_pc;
   logic [31:0]   out_instruction;
   logic          out_valid;
   logic [AW:0]   loop_len;
   logic [1:0]    dbg_state;
   logic [AW-1:0] dbg_rd_ptr;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] body[$];
   int m_idx = 0;

   loop_buffer_ctrl dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .curr_PC(curr_PC),
      .instruction(instruction), .immediate(immediate), .bubble_idex(bubble_idex),
      .mispredict(mispredict), .block_signal(block_signal), .flush(flush),
      .new_pc(new_pc), .out_instruction(out_instruction), .out_valid(out_valid),
      .loop_len(loop_len), .dbg_state(dbg_state), .dbg_rd_ptr(dbg_rd_ptr)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] alu_word();
      logic [31:0] r;
      r = $urandom();
      return {r[31:7], 7'b0010011};
   endfunction

   function automatic logic [31:0] br_word();
      logic [31:0] r;
      r = $urandom();
      return {r[31:7], 7'b1100011};
   endfunction

   function automatic logic [31:0] jal_word();
      logic [31:0] r;
      r = $urandom();
      return {r[31:7], 7'b1101111};
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] word, input logic [31:0] imm);
      valid_in    = 1'b1;
      curr_PC     = pc;
      instruction = word;
      immediate   = imm;
      step();
      valid_in    = 1'b0;
   endtask

   task automatic check_state(input string tag, input logic [31:0] st, input logic [31:0] blk);
      check_eq({tag, "_state"}, 32'(dbg_state), st);
      check_eq({tag, "_block"}, 32'(block_signal), blk);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_state"}, 32'(dbg_state), ST_TRACK);
      check_eq({tag, "_block"}, 32'(block_signal), 32'd0);
      check_eq({tag, "_flush"}, 32'(flush), 32'd0);
      check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_new_pc"}, new_pc, 32'd0);
      check_eq({tag, "_out_instr"}, out_instruction, 32'd0);
      check_eq({tag, "_loop_len"}, 32'(loop_len), 32'd0);
      check_eq({tag, "_rd_ptr"}, 32'(dbg_rd_ptr), 32'd0);
   endtask

   // Drives the branch, then the loop body ending in the same branch; leaves the DUT in REPLAY.
   task automatic capture_loop(input logic [31:0] br, input int len);
      logic [31:0] imm;
      logic [31:0] base;
      logic [31:0] w;
      imm  = 32'd0 - 32'(4 * (len - 1));
      base = br + imm;
      body.delete();
      m_idx = 0;
      fetch(br, br_word(), imm);
      check_state("cap_enter", ST_CAPTURE, 32'd0);
      for (int i = 0; i < len; i++) begin
         w = (i == len - 1) ? br_word() : alu_word();
         body.push_back(w);
         fetch(base + 32'(4 * i), w, (i == len - 1) ? imm : $urandom());
         if (i < len - 1) check_state("cap_body", ST_CAPTURE, 32'd0);
      end
      check_state("arm", ST_ARM, 32'd1);
      check_eq("arm_out_valid", 32'(out_valid), 32'd0);
      check_eq("arm_loop_len", 32'(loop_len), 32'(len));
      check_eq("arm_new_pc", new_pc, br + 32'd4);
      step();
      check_state("replay_enter", ST_REPLAY, 32'd1);
      check_eq("replay_enter_rd_ptr", 32'(dbg_rd_ptr), 32'd0);
   endtask

   // One unstalled replay cycle, with an in-range candidate on fetch that must be ignored.
   task automatic replay_cycle();
      logic [31:0] exp;
      exp_q.push_back(body[m_idx]);
      m_idx = (m_idx + 1) % body.size();
      bubble_idex = 1'b0;
      valid_in    = 1'b1;
      curr_PC     = 32'h0000_0300;
      instruction = br_word();
      immediate   = 32'hFFFF_FFF8;
      exp = exp_q.pop_front();
      check_eq("replay_word", out_instruction, exp);
      check_eq("replay_valid", 32'(out_valid), 32'd1);
      check_eq("replay_flush", 32'(flush), 32'd0);
      step();
      valid_in = 1'b0;
   endtask

   task automatic stall_cycle();
      bubble_idex = 1'b1;
      step();
      check_eq("stall_word", out_instruction, body[m_idx]);
      check_eq("stall_rd_ptr", 32'(dbg_rd_ptr), 32'(m_idx));
      check_state("stall", ST_REPLAY, 32'd1);
   endtask

   task automatic mispredict_in_replay(input logic bub, input logic [31:0] exp_pc);
      mispredict  = 1'b1;
      bubble_idex = bub;
      #1;
      check_eq("mp_flush", 32'(flush), 32'd1);
      check_eq("mp_new_pc", new_pc, exp_pc);
      step();
      mispredict  = 1'b0;
      bubble_idex = 1'b0;
      #1;
      check_eq("mp_after_flush", 32'(flush), 32'd0);
      check_eq("mp_after_valid", 32'(out_valid), 32'd0);
      check_state("mp_after", ST_TRACK, 32'd0);
      step();
      check_eq("mp_after2_flush", 32'(flush), 32'd0);
   endtask

   initial begin
      reset       = 1'b0;
      valid_in    = 1'b0;
      curr_PC     = '0;
      instruction = '0;
      immediate   = '0;
      bubble_idex = 1'b0;
      mispredict  = 1'b0;
      #1;
      check_all_zero("por");
      step();
      step();
      reset = 1'b1;
      check_state("post_reset", ST_TRACK, 32'd0);

      // 4-instruction loop, replay with wrap, stall, then mispredict with a bubble
      capture_loop(32'h0000_010C, 4);
      for (int i = 0; i < 5; i++) replay_cycle();
      for (int i = 0; i < 3; i++) stall_cycle();
      bubble_idex = 1'b0;
      for (int i = 0; i < 3; i++) replay_cycle();
      mispredict_in_replay(1'b1, 32'h0000_0110);

      // offsets outside the accepted range, and a forward branch
      fetch(32'h0000_0200, br_word(), 32'hFFFF_FF7C);
      check_state("oor_132", ST_TRACK, 32'd0);
      for (int i = 0; i < 4; i++) begin
         fetch(32'h0000_017C + 32'(4 * i), alu_word(), 32'd0);
         check_state("oor_follow", ST_TRACK, 32'd0);
      end
      fetch(32'h0000_0200, br_word(), 32'h0000_0010);
      check_state("fwd_branch", ST_TRACK, 32'd0);

      // largest offset is accepted, but the body overflows the buffer
      fetch(32'h0000_0200, br_word(), 32'hFFFF_FF80);
      check_state("max_off", ST_CAPTURE, 32'd0);
      for (int i = 0; i < 31; i++) fetch(32'h0000_0180 + 32'(4 * i), alu_word(), 32'd0);
      check_state("depth_edge", ST_CAPTURE, 32'd0);
      fetch(32'h0000_01FC, alu_word(), 32'd0);
      check_state("depth_abort", ST_TRACK, 32'd0);

      // PC discontinuity aborts capture
      fetch(32'h0000_0600, br_word(), 32'hFFFF_FFF8);
      fetch(32'h0000_05F8, alu_word(), 32'd0);
      fetch(32'h0000_0700, alu_word(), 32'd0);
      check_state("pc_gap", ST_TRACK, 32'd0);

      // mispredict during capture returns quietly
      fetch(32'h0000_0500, br_word(), 32'hFFFF_FFF8);
      mispredict = 1'b1;
      #1;
      check_eq("cap_mp_flush", 32'(flush), 32'd0);
      step();
      mispredict = 1'b0;
      check_state("cap_mp", ST_TRACK, 32'd0);

      // JAL inside the body aborts; a backward JAL must not restart capture
      fetch(32'h0000_010C, br_word(), 32'hFFFF_FFF4);
      fetch(32'h0000_0100, alu_word(), 32'd0);
      fetch(32'h0000_0104, jal_word(), 32'hFFFF_FFFC);
      check_state("jal_abort", ST_TRACK, 32'd0);
      fetch(32'h0000_0108, alu_word(), 32'd0);
      check_state("jal_follow", ST_TRACK, 32'd0);
      check_eq("jal_new_pc_held", new_pc, 32'h0000_0110);

      // 2-instruction loop, mispredict without a bubble
      capture_loop(32'h0000_0400, 2);
      for (int i = 0; i < 4; i++) replay_cycle();
      mispredict_in_replay(1'b0, 32'h0000_0404);

      // reset mid-capture, then a clean capture and replay
      fetch(32'h0000_010C, br_word(), 32'hFFFF_FFF4);
      fetch(32'h0000_0100, alu_word(), 32'd0);
      fetch(32'h0000_0104, alu_word(), 32'd0);
      check_state("pre_reset_cap", ST_CAPTURE, 32'd0);
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("mid_reset");
      step();
      reset = 1'b1;
      fetch(32'h0000_0108, alu_word(), 32'd0);
      check_state("post_reset_discard", ST_TRACK, 32'd0);
      capture_loop(32'h0000_010C, 4);
      for (int i = 0; i < 5; i++) replay_cycle();
      mispredict_in_replay(1'b0, 32'h0000_0110);

      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
